// File: rtl/elevator_pkg.sv
// Shared constants for the elevator status display: segment patterns, digit slots, status payload.
package elevator_pkg;

    localparam int unsigned IDX_W   = 2;
    localparam int unsigned BLANK_W = 4;
    localparam int unsigned CODE_W  = 4;

    // Active-low g..a patterns; the decimal point is handled separately as seg[7].
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_U   = 7'h41;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_O   = 7'h23;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [IDX_W-1:0] DIG_FLOOR = 2'd3;
    localparam logic [IDX_W-1:0] DIG_DIR   = 2'd2;
    localparam logic [IDX_W-1:0] DIG_PPL   = 2'd1;
    localparam logic [IDX_W-1:0] DIG_DOOR  = 2'd0;

    typedef struct packed {
        logic [2:0] floor;
        logic [2:0] people;
        logic       dir;
        logic       door;
    } status_t;

endpackage

// File: rtl/elevator_display_seg7_encode.sv
// Combinational decimal code to active-low seven-segment pattern; unused codes blank.
module seg7_encode
    import elevator_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [6:0]        seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (code_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/elevator_display.sv
// Four-digit multiplexed status display with frame snapshot, anti-ghost blanking and blink.
module elevator_display
    import elevator_pkg::*;
#(
    parameter int unsigned BLANK_CYC  = 4,
    parameter int unsigned PEOPLE_MAX = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_tick,
    input  logic       blink_tick,
    input  logic [2:0] floor,
    input  logic [2:0] people,
    input  logic       dir,
    input  logic       door,
    output logic [3:0] an,
    output logic [7:0] seg
);

    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [BLANK_W-1:0] blank_q, blank_d;
    logic               phase_q, phase_d;
    status_t            snap_q,  snap_d;
    logic [3:0]         an_q,    an_d;
    logic [7:0]         seg_q,   seg_d;

    logic [CODE_W-1:0]  floor_code_c;
    logic [CODE_W-1:0]  ppl_code_c;
    logic [6:0]         floor_seg_c;
    logic [6:0]         ppl_seg_c;
    logic               overload_c;

    // Encoders look at the next-state snapshot so outputs land with the new idx.
    assign floor_code_c = CODE_W'(snap_d.floor) + CODE_W'(1);
    assign ppl_code_c   = CODE_W'(snap_d.people);
    assign overload_c   = (snap_d.people == 3'(PEOPLE_MAX));

    seg7_encode u_floor_enc (
        .code_i (floor_code_c),
        .seg_o  (floor_seg_c)
    );

    seg7_encode u_ppl_enc (
        .code_i (ppl_code_c),
        .seg_o  (ppl_seg_c)
    );

    always_comb begin
        idx_d   = idx_q;
        blank_d = blank_q;
        phase_d = phase_q;
        snap_d  = snap_q;
        an_d    = 4'hF;
        seg_d   = 8'hFF;

        if (scan_tick) begin
            idx_d   = idx_q + IDX_W'(1);
            blank_d = BLANK_W'(BLANK_CYC);
            if (idx_q == DIG_FLOOR) begin
                snap_d = '{floor: floor, people: people, dir: dir, door: door};
            end
        end else if (blank_q != '0) begin
            blank_d = blank_q - BLANK_W'(1);
        end

        if (blink_tick) begin
            phase_d = ~phase_q;
        end

        if (blank_d == '0) begin
            an_d = ~(4'b0001 << idx_d);
        end

        case (idx_d)
            DIG_FLOOR: seg_d = {1'b1, floor_seg_c};
            DIG_DIR:   seg_d = {1'b1, snap_d.dir ? SEG_U : SEG_D};
            DIG_PPL:   seg_d = (overload_c && phase_d) ? 8'hFF : {1'b1, ppl_seg_c};
            DIG_DOOR:  seg_d = snap_d.door ? {phase_d, SEG_O} : {1'b1, SEG_C};
            default:   seg_d = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            blank_q <= '0;
            phase_q <= 1'b0;
            snap_q  <= '0;
            an_q    <= 4'hF;
            seg_q   <= 8'hFF;
        end else begin
            idx_q   <= idx_d;
            blank_q <= blank_d;
            phase_q <= phase_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_elevator_display.sv
// Scoreboarded bench: a digit-level display model predicts an/seg each clk, a monitor compares.
module tb_elevator_display;

    localparam int BLANK_CYC  = 4;
    localparam int PEOPLE_MAX = 7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_tick;
    logic       blink_tick;
    logic [2:0] floor;
    logic [2:0] people;
    logic       dir;
    logic       door;
    logic [3:0] an;
    logic [7:0] seg;

    elevator_display #(
        .BLANK_CYC  (BLANK_CYC),
        .PEOPLE_MAX (PEOPLE_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_tick  (scan_tick),
        .blink_tick (blink_tick),
        .floor      (floor),
        .people     (people),
        .dir        (dir),
        .door       (door),
        .an         (an),
        .seg        (seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        bit         seg_chk;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Full 8-bit glyphs for decimal digits 0..9 as seen on the pins
    logic [7:0] digit_glyph [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // Reference model state: which digit is lit, cycles of darkness left, blink phase, frame data
    int m_digit;
    int m_dark;
    bit m_phase;
    int f_floor;
    int f_people;
    bit f_up;
    bit f_open;

    function automatic logic [7:0] glyph_for(int digit);
        logic [7:0] g;
        case (digit)
            3:       g = digit_glyph[f_floor + 1];
            2:       g = f_up ? 8'hC1 : 8'hA1;
            1:       g = (f_people == PEOPLE_MAX && m_phase) ? 8'hFF : digit_glyph[f_people];
            default: g = f_open ? (m_phase ? 8'hA3 : 8'h23) : 8'hC6;
        endcase
        return g;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            m_digit = 0; m_dark = 0; m_phase = 0;
            f_floor = 0; f_people = 0; f_up = 0; f_open = 0;
            e.an = 4'hF; e.seg = 8'hFF; e.seg_chk = 1;
        end else begin
            if (scan_tick) begin
                if (m_digit == 3) begin
                    f_floor = int'(floor); f_people = int'(people);
                    f_up = dir; f_open = door;
                end
                m_digit = (m_digit + 1) % 4;
                m_dark  = BLANK_CYC;
            end else if (m_dark > 0) begin
                m_dark = m_dark - 1;
            end
            if (blink_tick) m_phase = !m_phase;
            e.an      = (m_dark > 0) ? 4'hF : 4'(15 - (1 << m_digit));
            e.seg     = glyph_for(m_digit);
            e.seg_chk = (m_dark == 0);
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (an !== e.an) begin
                n_fail++;
                $display("FAIL an t=%0t got=%b want=%b", $time, an, e.an);
            end
            if (e.seg_chk) begin
                n_checks++;
                if (seg !== e.seg) begin
                    n_fail++;
                    $display("FAIL seg t=%0t an=%b got=%h want=%h", $time, an, seg, e.seg);
                end
            end
        end
    end

    task automatic cyc(input bit s, input bit b);
        scan_tick  = s;
        blink_tick = b;
        @(negedge clk);
        scan_tick  = 1'b0;
        blink_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0);
    endtask

    // One scan step followed by enough idle time to get past blanking
    task automatic scan_step(input bit b);
        cyc(1, b);
        idle(BLANK_CYC + 3);
    endtask

    initial begin
        rst_n = 1'b0; scan_tick = 1'b0; blink_tick = 1'b0;
        floor = 3'd0; people = 3'd0; dir = 1'b0; door = 1'b0;
        @(negedge clk);

        // Reset held with ticks pulsing
        repeat (3) cyc(1, 1);
        rst_n = 1'b1;
        idle(3);
        scan_step(0);

        // Basic frame
        floor = 3'd2; people = 3'd3; dir = 1'b1; door = 1'b0;
        repeat (3) scan_step(0);
        repeat (4) scan_step(0);

        // Tear-free: change floor while idx=1
        scan_step(0);
        floor = 3'd5;
        repeat (8) scan_step(0);

        // Overload flashing and a non-overload neighbour
        people = 3'd7;
        repeat (8) scan_step(1);
        people = 3'd6;
        repeat (8) scan_step(1);

        // Door open with dp blink
        door = 1'b1;
        repeat (12) scan_step(1);

        // Simultaneous ticks, scan during blanking
        cyc(1, 1);
        idle(2);
        cyc(1, 0);
        idle(1);
        cyc(1, 1);
        idle(BLANK_CYC + 4);

        // Reset mid-scan
        scan_step(0);
        rst_n = 1'b0;
        cyc(1, 1);
        rst_n = 1'b1;
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom % 500) != 0;
            if ($urandom % 12 == 0) floor  = 3'($urandom);
            if ($urandom % 12 == 0) people = 3'($urandom);
            if ($urandom % 20 == 0) dir    = 1'($urandom);
            if ($urandom % 20 == 0) door   = 1'($urandom);
            cyc(($urandom % 5) == 0, ($urandom % 9) == 0);
        end
        rst_n = 1'b1;
        idle(2);

        n_checks++;
        if (exp_q.size() > 1) begin
            n_fail++;
            $display("FAIL drain got=%0d pending want<=1", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
